// File: rtl/progrom_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : progrom_loader_if
// Description : Program-memory write/read bus between the ICSP loader and
//               the CQPIC program store.
//                 mem_addr  - word address (loader drives)
//                 mem_wdata - write data   (loader drives)
//                 mem_we    - one-clk write strobe (loader drives)
//                 mem_rdata - registered read data, valid 1 clk after addr
// Revision    : 1.0 - initial release
// ============================================================================
interface progrom_loader_if #(
  parameter int AW = 13,
  parameter int DW = 14
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface
`default_nettype wire

// File: rtl/progrom_loader.sv
`default_nettype none
// ============================================================================
// Module      : progrom_loader
// Description : ICSP-style serial programming port for the CQPIC program
//               memory. 6-bit commands and 16-bit data frames (LSB first)
//               arrive on an external clock/data pair that is oversampled in
//               the clk domain. While programming mode is active the CPU is
//               held and the loader owns the memory bus.
// Ports       : clk        - system clock
//               reset_n    - asynchronous active-low reset
//               prog_en    - programming-mode request (async)
//               icsp_clk   - external serial clock (async)
//               icsp_din   - external serial data (async)
//               icsp_dout  - serial read-back data
//               icsp_doe   - output enable for icsp_dout
//               cpu_hold   - stall request to the core
//               mem        - program memory bus (master side)
// Options     : PROGROM_LOADER_READBACK_EN - compiles in the READ command,
//               the RDREQ/DREAD states and the icsp_dout/icsp_doe drive.
// Revision    : 1.0 - initial release
// ============================================================================
module progrom_loader #(
  parameter int AW          = 13,
  parameter int DW          = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              prog_en,
  input  logic              icsp_clk,
  input  logic              icsp_din,
  output logic              icsp_dout,
  output logic              icsp_doe,
  output logic              cpu_hold,
  progrom_loader_if.master  mem
);

  localparam int c_fw = DW + 2;              // frame: start, DW data, stop
  localparam int c_cw = $clog2(c_fw);

  localparam logic [5:0] c_cmd_load = 6'h02;
  localparam logic [5:0] c_cmd_read = 6'h04;
  localparam logic [5:0] c_cmd_inc  = 6'h06;
  localparam logic [5:0] c_cmd_burn = 6'h08;
  localparam logic [5:0] c_cmd_clr  = 6'h16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_DLOAD = 3'd2,
    S_BURN  = 3'd3,
    S_RDREQ = 3'd4,
    S_DREAD = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_din_sync, r_pen_sync;
  logic              r_clk_q;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic              r_load_valid;
  logic [c_fw-1:0]   r_shift;
  logic [c_cw-1:0]   r_bitcnt;
`ifdef PROGROM_LOADER_READBACK_EN
  logic              r_dout;
  logic              r_rd_wait;
`endif

  logic w_sclk, w_sdin, w_spen, w_fall, w_rise;
  logic w_last_cmd, w_last_frame;
  logic [5:0] w_cmd;

  assign w_sclk = r_clk_sync[SYNC_STAGES-1];
  assign w_sdin = r_din_sync[SYNC_STAGES-1];
  assign w_spen = r_pen_sync[SYNC_STAGES-1];
  assign w_fall = r_clk_q & ~w_sclk;
  assign w_rise = ~r_clk_q & w_sclk;

  assign w_last_cmd   = (r_bitcnt == c_cw'(5));
  assign w_last_frame = (r_bitcnt == c_cw'(c_fw - 1));
  // Bits enter at the MSB, so after six shifts the command occupies the top
  // six positions; the bit arriving this clk is its MSB.
  assign w_cmd = {w_sdin, r_shift[c_fw-1 -: 5]};

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (r_state != S_IDLE && !w_spen) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_spen) w_state_nxt = S_CMD;
        S_CMD: begin
          if (w_fall && w_last_cmd) begin
            case (w_cmd)
              c_cmd_load: w_state_nxt = S_DLOAD;
              c_cmd_burn: w_state_nxt = S_BURN;
`ifdef PROGROM_LOADER_READBACK_EN
              c_cmd_read: w_state_nxt = S_RDREQ;
`endif
              default:    w_state_nxt = S_CMD;
            endcase
          end
        end
        S_DLOAD: if (w_fall && w_last_frame) w_state_nxt = S_CMD;
        S_BURN:  w_state_nxt = S_CMD;
`ifdef PROGROM_LOADER_READBACK_EN
        S_RDREQ: if (r_rd_wait) w_state_nxt = S_DREAD;
        S_DREAD: if (w_fall && w_last_frame) w_state_nxt = S_CMD;
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register, synchronisers and datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_clk_sync   <= '0;
      r_din_sync   <= '0;
      r_pen_sync   <= '0;
      r_clk_q      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_load_valid <= 1'b0;
      r_shift      <= '0;
      r_bitcnt     <= '0;
`ifdef PROGROM_LOADER_READBACK_EN
      r_dout       <= 1'b0;
      r_rd_wait    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], icsp_clk};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], icsp_din};
      r_pen_sync <= {r_pen_sync[SYNC_STAGES-2:0], prog_en};
      r_clk_q    <= w_sclk;

      if (r_state == S_IDLE || !w_spen) begin
        // Idle or aborting: discard any pending load and partial frame.
        r_addr       <= '0;
        r_wdata      <= '0;
        r_load_valid <= 1'b0;
        r_bitcnt     <= '0;
`ifdef PROGROM_LOADER_READBACK_EN
        r_dout       <= 1'b0;
        r_rd_wait    <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_CMD: begin
            if (w_fall) begin
              r_shift <= {w_sdin, r_shift[c_fw-1:1]};
              if (w_last_cmd) begin
                r_bitcnt <= '0;
                if (w_cmd == c_cmd_inc) r_addr <= r_addr + 1'b1;
                if (w_cmd == c_cmd_clr) r_addr <= '0;
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end
          S_DLOAD: begin
            if (w_fall) begin
              r_shift <= {w_sdin, r_shift[c_fw-1:1]};
              if (w_last_frame) begin
                // Incoming bit is the stop bit; data sits one above the
                // start bit in the not-yet-shifted register.
                r_bitcnt     <= '0;
                r_wdata      <= r_shift[DW+1:2];
                r_load_valid <= 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end
          S_BURN: r_load_valid <= 1'b0;
`ifdef PROGROM_LOADER_READBACK_EN
          S_RDREQ: begin
            r_rd_wait <= 1'b1;
            if (r_rd_wait) begin
              r_rd_wait <= 1'b0;
              r_dout    <= 1'b0;
              r_shift   <= {1'b0, mem.mem_rdata, 1'b0};
            end
          end
          S_DREAD: begin
            if (w_rise) begin
              r_dout  <= r_shift[0];
              r_shift <= {1'b0, r_shift[c_fw-1:1]};
            end
            if (w_fall) begin
              if (w_last_frame) begin
                r_bitcnt <= '0;
                r_dout   <= 1'b0;
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign cpu_hold      = (r_state != S_IDLE);
  assign mem.mem_addr  = cpu_hold ? r_addr : '0;
  assign mem.mem_wdata = r_wdata;
  // Gated by the synced enable so an abort landing on BURN issues no write.
  assign mem.mem_we    = (r_state == S_BURN) && r_load_valid && w_spen;

`ifdef PROGROM_LOADER_READBACK_EN
  assign icsp_dout = r_dout;
  assign icsp_doe  = (r_state == S_DREAD);
`else
  assign icsp_dout = 1'b0;
  assign icsp_doe  = 1'b0;
  logic w_unused_bits;
  assign w_unused_bits = ^{mem.mem_rdata, r_shift[0], w_rise};
`endif

endmodule
`default_nettype wire

// File: doc/progrom_loader.md
Name: progrom_loader

Overview:
- Serial in-circuit programming port that writes 14-bit words into the CQPIC program memory, and optionally reads them back.
- It is the writer side of the program store that the core fetches from.
- Command set is ICSP-like: 6-bit commands plus 16-bit data frames on a slow external clock/data pair, which is oversampled in the `clk` domain.
- While programming mode is active, the block holds the CPU and owns the memory address, write-data and write-enable lines.

Parameters:
- AW, 13, program memory address width (words).
- DW, 14, instruction word width.
- SYNC_STAGES, 2, synchroniser flops on icsp_clk, icsp_din and prog_en (minimum 2).

Ports:
- clk  input  1  system clock; the only clock in the block.
- reset_n  input  1  asynchronous active-low reset.
- prog_en  input  1  programming-mode request (asynchronous; synchronised internally).
- icsp_clk  input  1  external serial clock (asynchronous; synchronised internally).
- icsp_din  input  1  external serial data in.
- icsp_dout  output  1  serial read-back data.
- icsp_doe  output  1  output enable for icsp_dout.
- cpu_hold  output  1  high while programming mode is active; the core stalls and releases memory.
- mem_addr  output  AW  program memory address.
- mem_wdata  output  DW  write data.
- mem_we  output  1  one-clk write strobe.
- mem_rdata  input  DW  memory read data, registered output, valid 1 clk after mem_addr.

Behaviour:
- Reset values: all outputs 0, state IDLE, address counter 0, load_valid 0.
- Synchronisation and sampling: icsp_clk, icsp_din and prog_en each pass through SYNC_STAGES flops.
  - Edge detection is done on synced icsp_clk.
  - Input bits are sampled on each synced falling edge.
  - Output bits change on each synced rising edge.
  - All serial fields are LSB first.
- IDLE: cpu_hold=0. When synced prog_en goes high: address=0, load_valid=0, cpu_hold=1, go to CMD.
- CMD: shift 6 bits, then decode [5:0]:
  - 0x02 LOAD: go to DLOAD.
  - 0x04 READ: go to RDREQ.
  - 0x06 INC: address+1, wrapping 2^AW-1 to 0; return to CMD.
  - 0x08 BURN: go to BURN.
  - 0x16 ADDR_CLR: address=0; return to CMD.
  - Any other code: ignored; return to CMD with no side effect.
- DLOAD: receive a 16-bit frame (start bit, DW data bits, stop bit). Start and stop bits are discarded and not checked. Latch data bits into the write-data register, set load_valid=1, return to CMD.
- BURN: exactly 1 clk.
  - If load_valid=1: mem_we=1 with mem_wdata=latched word and mem_addr=address, then load_valid=0.
  - If load_valid=0: no strobe.
  - Address is not auto-incremented. Return to CMD.
- RDREQ: present the address and wait 1 clk, then capture mem_rdata into the shift register and go to DREAD.
- DREAD: icsp_doe=1 for 16 rising edges. Output order: 0 start bit, DW data bits, 0 stop bit. After the 16th falling edge, icsp_doe=0 and return to CMD.
- mem_addr is continuously driven from the address counter whenever cpu_hold=1, and is 0 otherwise.
- prog_en deasserted in any state (synced): abort to IDLE next clk.
  - No write is issued; a pending load is discarded.
  - icsp_doe, cpu_hold and mem_we all go to 0.
  - Address resets to 0.
- reset_n low mid-operation: immediate return to reset values. A mem_we pulse in flight is cut.
- icsp_clk edges arriving while IDLE are ignored.

Optional Feature:
- PROGROM_LOADER_READBACK_EN
  - Defined: the READ command (0x04), RDREQ/DREAD states, icsp_dout/icsp_doe drive and mem_rdata use are compiled in, as described above.
  - Undefined: 0x04 is treated as an unknown command and ignored; icsp_dout and icsp_doe are tied to 0; mem_rdata is unused.

Test Plan:
- Reset with prog_en=1 held: all outputs 0. After release: cpu_hold=1 within SYNC_STAGES+2 clks, mem_addr=0.
- Command sequence LOAD 0x2A5F, BURN, INC, LOAD 0x0001, BURN:
  - mem_we pulses exactly twice, each 1 clk wide.
  - First pulse: addr 0, data 0x2A5F. Second pulse: addr 1, data 0x0001.
- BURN with no preceding LOAD, and a second BURN straight after a write: no mem_we pulse in either case.
- 8191 INCs followed by one more INC: mem_addr goes 8191, then 0.
- READ at addr 5 with the model memory returning 0x1234: icsp_dout bitstream is 0, then 0x1234 LSB first, then 0; icsp_doe=1 for exactly 16 bit times. With the macro undefined: icsp_doe stays 0 and the next command still decodes correctly.
- prog_en dropped halfway through a DLOAD frame:
  - No mem_we; cpu_hold=0 within SYNC_STAGES+1 clks.
  - On re-entry, address=0 and BURN produces no write.
